automatic_washing_machine: RTL and testbench



---
 rtl/automatic_washing_machine.sv | 165 ++++++++++++++++
 tb/tb_automatic_washing_machine.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/automatic_washing_machine.sv
// rtl/automatic_washing_machine.sv - washing machine sequencing FSM with registered actuator outputs
module automatic_washing_machine (
    input  logic clk,
    input  logic reset,
    input  logic door_close,
    input  logic start,
    input  logic filled,
    input  logic detergent_added,
    input  logic cycle_timeout,
    input  logic drained,
    input  logic spin_timeout,
    output logic door_lock,
    output logic motor_on,
    output logic fill_value_on,
    output logic drain_value_on,
    output logic done,
    output logic soap_wash,
    output logic water_wash
);

    typedef enum logic [2:0] {
        CHECK_DOOR    = 3'd0,
        FILL_WATER    = 3'd1,
        ADD_DETERGENT = 3'd2,
        CYCLE         = 3'd3,
        DRAIN_WATER   = 3'd4,
        SPIN          = 3'd5
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_soap_wash;
    logic   r_water_wash;
    logic   r_door_lock;
    logic   r_motor_on;
    logic   r_fill_on;
    logic   r_drain_on;
    logic   r_done;
    logic   w_next_soap;
    logic   w_next_water;
    logic   w_next_done;
    logic   w_next_lock;
    logic   w_next_motor;
    logic   w_next_fill;
    logic   w_next_drain;

    // Next state and pass flags; only the current state's own condition is looked at
    always_comb begin
        w_next_state = r_state;
        w_next_soap  = r_soap_wash;
        w_next_water = r_water_wash;
        w_next_done  = 1'b0;
        case (r_state)
            CHECK_DOOR: begin
                if (start && door_close) begin
                    w_next_state = FILL_WATER;
                end
            end
            FILL_WATER: begin
                if (filled) begin
                    if (!r_soap_wash) begin
                        w_next_state = ADD_DETERGENT;
                        w_next_soap  = 1'b1;
                    end else begin
                        w_next_state = CYCLE;
                        w_next_water = 1'b1;
                    end
                end
            end
            ADD_DETERGENT: begin
                if (detergent_added) begin
                    w_next_state = CYCLE;
                end
            end
            CYCLE: begin
                if (cycle_timeout) begin
                    w_next_state = DRAIN_WATER;
                end
            end
            DRAIN_WATER: begin
                if (drained) begin
                    w_next_state = r_water_wash ? SPIN : FILL_WATER;
                end
            end
            SPIN: begin
                if (spin_timeout) begin
                    w_next_state = CHECK_DOOR;
                    w_next_done  = 1'b1;
                    w_next_soap  = 1'b0;
                    w_next_water = 1'b0;
                end
            end
            default: begin
                w_next_state = CHECK_DOOR;
                w_next_soap  = 1'b0;
                w_next_water = 1'b0;
            end
        endcase
    end

    // Actuator values decoded from the state being entered so outputs can be registered
    always_comb begin
        w_next_lock  = 1'b0;
        w_next_motor = 1'b0;
        w_next_fill  = 1'b0;
        w_next_drain = 1'b0;
        case (w_next_state)
            FILL_WATER: begin
                w_next_lock = 1'b1;
                w_next_fill = 1'b1;
            end
            ADD_DETERGENT: begin
                w_next_lock = 1'b1;
            end
            CYCLE: begin
                w_next_lock  = 1'b1;
                w_next_motor = 1'b1;
            end
            DRAIN_WATER: begin
                w_next_lock  = 1'b1;
                w_next_drain = 1'b1;
            end
            SPIN: begin
                w_next_lock  = 1'b1;
                w_next_motor = 1'b1;
                w_next_drain = 1'b1;
            end
            default: begin
                w_next_lock = 1'b0;
            end
        endcase
    end

    // State, flags and outputs; reset drops everything at once with no drain/unlock sequencing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= CHECK_DOOR;
            r_soap_wash  <= 1'b0;
            r_water_wash <= 1'b0;
            r_door_lock  <= 1'b0;
            r_motor_on   <= 1'b0;
            r_fill_on    <= 1'b0;
            r_drain_on   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_soap_wash  <= w_next_soap;
            r_water_wash <= w_next_water;
            r_door_lock  <= w_next_lock;
            r_motor_on   <= w_next_motor;
            r_fill_on    <= w_next_fill;
            r_drain_on   <= w_next_drain;
            r_done       <= w_next_done;
        end
    end

    assign door_lock      = r_door_lock;
    assign motor_on       = r_motor_on;
    assign fill_value_on  = r_fill_on;
    assign drain_value_on = r_drain_on;
    assign done           = r_done;
    assign soap_wash      = r_soap_wash;
    assign water_wash     = r_water_wash;

endmodule

// File: tb/tb_automatic_washing_machine.sv
// tb/tb_automatic_washing_machine.sv - scoreboard bench for automatic_washing_machine
module tb_automatic_washing_machine;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic door_close = 1'b0;
    logic start = 1'b0;
    logic filled = 1'b0;
    logic detergent_added = 1'b0;
    logic cycle_timeout = 1'b0;
    logic drained = 1'b0;
    logic spin_timeout = 1'b0;
    logic door_lock;
    logic motor_on;
    logic fill_value_on;
    logic drain_value_on;
    logic done;
    logic soap_wash;
    logic water_wash;

    int n_checks = 0;
    int n_pass   = 0;
    logic [6:0] exp_q[$];

    // Output vector layout: {lock, motor, fill, drain, done, soap, water}
    localparam logic [6:0] O_IDLE = 7'b0000000;
    localparam logic [6:0] O_FILL = 7'b1010000;
    localparam logic [6:0] O_ADD  = 7'b1000000;
    localparam logic [6:0] O_CYC  = 7'b1100000;
    localparam logic [6:0] O_DRN  = 7'b1001000;
    localparam logic [6:0] O_SPIN = 7'b1101000;
    localparam logic [6:0] O_DONE = 7'b0000100;
    localparam logic [6:0] F_SOAP = 7'b0000010;
    localparam logic [6:0] F_BOTH = 7'b0000011;

    automatic_washing_machine dut (
        .clk             (clk),
        .reset           (reset),
        .door_close      (door_close),
        .start           (start),
        .filled          (filled),
        .detergent_added (detergent_added),
        .cycle_timeout   (cycle_timeout),
        .drained         (drained),
        .spin_timeout    (spin_timeout),
        .door_lock       (door_lock),
        .motor_on        (motor_on),
        .fill_value_on   (fill_value_on),
        .drain_value_on  (drain_value_on),
        .done            (done),
        .soap_wash       (soap_wash),
        .water_wash      (water_wash)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] outs();
        return {door_lock, motor_on, fill_value_on, drain_value_on, done, soap_wash, water_wash};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // sens = {filled, detergent_added, cycle_timeout, drained, spin_timeout}
    task automatic drive(input logic st, input logic dc, input logic [4:0] sens);
        start           = st;
        door_close      = dc;
        filled          = sens[4];
        detergent_added = sens[3];
        cycle_timeout   = sens[2];
        drained         = sens[1];
        spin_timeout    = sens[0];
    endtask

    // Push the expected outputs for the coming edge, then pop and compare after it
    task automatic step(input string tag, input logic [6:0] exp_o);
        logic [6:0] e;
        exp_q.push_back(exp_o);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, {1'b0, outs()}, {1'b0, e});
        check({tag, "_excl"}, {7'd0, fill_value_on & drain_value_on}, 8'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #3;
        check("rst_async", {1'b0, outs()}, 8'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        // reset with random inputs
        @(posedge clk);
        #1;
        drive(1'($urandom), 1'($urandom), 5'($urandom));
        @(posedge clk);
        #2;
        check("reset_outs", {1'b0, outs()}, 8'd0);
        drive(1'b1, 1'b0, 5'b00000);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) step("no_door", O_IDLE);

        // sequential sensors, 2 cycles apart, left high
        do_reset();
        drive(1'b1, 1'b1, 5'b00000);
        step("seq_fill1", O_FILL);
        drive(1'b0, 1'b1, 5'b00000);
        step("seq_fill1_hold", O_FILL);
        drive(1'b0, 1'b1, 5'b10000);
        step("seq_add", O_ADD | F_SOAP);
        step("seq_add_hold", O_ADD | F_SOAP);
        drive(1'b0, 1'b1, 5'b11000);
        step("seq_cyc1", O_CYC | F_SOAP);
        step("seq_cyc1_hold", O_CYC | F_SOAP);
        drive(1'b0, 1'b1, 5'b11100);
        step("seq_drn1", O_DRN | F_SOAP);
        step("seq_drn1_hold", O_DRN | F_SOAP);
        drive(1'b0, 1'b1, 5'b11110);
        step("seq_fill2", O_FILL | F_SOAP);
        step("seq_cyc2", O_CYC | F_BOTH);
        step("seq_drn2", O_DRN | F_BOTH);
        step("seq_spin", O_SPIN | F_BOTH);
        step("seq_spin_hold", O_SPIN | F_BOTH);
        drive(1'b0, 1'b1, 5'b11111);
        step("seq_done", O_DONE);
        step("seq_idle", O_IDLE);

        // everything held high from reset release; second run follows done
        do_reset();
        drive(1'b1, 1'b1, 5'b11111);
        reset = 1'b0;
        #2;
        reset = 1'b1;
        step("all_fill1", O_FILL);
        step("all_add", O_ADD | F_SOAP);
        step("all_cyc1", O_CYC | F_SOAP);
        step("all_drn1", O_DRN | F_SOAP);
        step("all_fill2", O_FILL | F_SOAP);
        step("all_cyc2", O_CYC | F_BOTH);
        step("all_drn2", O_DRN | F_BOTH);
        step("all_spin", O_SPIN | F_BOTH);
        step("all_done", O_DONE);
        step("all_rerun", O_FILL);
        step("all_rerun_add", O_ADD | F_SOAP);

        // door opening while locked is ignored
        do_reset();
        drive(1'b1, 1'b1, 5'b11111);
        step("door_fill1", O_FILL);
        step("door_add", O_ADD | F_SOAP);
        step("door_cyc1", O_CYC | F_SOAP);
        drive(1'b1, 1'b0, 5'b11111);
        step("door_drn1", O_DRN | F_SOAP);
        step("door_fill2", O_FILL | F_SOAP);
        step("door_cyc2", O_CYC | F_BOTH);
        step("door_drn2", O_DRN | F_BOTH);
        step("door_spin", O_SPIN | F_BOTH);
        step("door_done", O_DONE);
        step("door_stay", O_IDLE);

        // reset in second-pass drain, then a fresh soap pass
        do_reset();
        drive(1'b1, 1'b1, 5'b11111);
        step("mid_fill1", O_FILL);
        step("mid_add", O_ADD | F_SOAP);
        step("mid_cyc1", O_CYC | F_SOAP);
        step("mid_drn1", O_DRN | F_SOAP);
        step("mid_fill2", O_FILL | F_SOAP);
        step("mid_cyc2", O_CYC | F_BOTH);
        step("mid_drn2", O_DRN | F_BOTH);
        #2;
        reset = 1'b0;
        #1;
        check("mid_async_clear", {1'b0, outs()}, 8'd0);
        #1;
        reset = 1'b1;
        step("mid_restart_fill", O_FILL);
        step("mid_restart_add", O_ADD | F_SOAP);

        // filled held low keeps the inlet valve open
        do_reset();
        drive(1'b1, 1'b1, 5'b00000);
        step("wait_enter", O_FILL);
        for (int i = 0; i < 20; i++) step("wait_fill", O_FILL);
        drive(1'b1, 1'b1, 5'b10000);
        step("wait_exit", O_ADD | F_SOAP);

        check("queue_empty", 8'(exp_q.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
